// File: rtl/pipemem_stage_if.sv
// EX/MEM -> MEM/WB bus of the memory pipeline stage, plus the stall and misalign flags.
interface pipemem_stage_if;
    logic        i_wreg;
    logic        i_m2reg;
    logic        i_wmem;
    logic [31:0] i_alu;
    logic [31:0] i_b;
    logic [4:0]  i_rn;
    logic        o_wreg;
    logic        o_m2reg;
    logic [31:0] o_mo;
    logic [31:0] o_alu;
    logic [4:0]  o_rn;
    logic        o_stall;
    logic        o_misalign;

    modport master (
        output i_wreg, i_m2reg, i_wmem, i_alu, i_b, i_rn,
        input  o_wreg, o_m2reg, o_mo, o_alu, o_rn, o_stall, o_misalign
    );

    modport slave (
        input  i_wreg, i_m2reg, i_wmem, i_alu, i_b, i_rn,
        output o_wreg, o_m2reg, o_mo, o_alu, o_rn, o_stall, o_misalign
    );
endinterface

// File: rtl/pipemem_stage.sv
// MEM pipeline stage: word-addressed data memory with a fixed number of wait states per access,
// stalling upstream and inserting bubbles into MEM/WB until the access completes.
module pipemem_stage #(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    pipemem_stage_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [0:0]        state;
    logic [3:0]        cnt;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] addr;
    logic              mem_op;
    logic              misaligned;
    logic              stall;
    logic              capture;

    always_comb begin
        mem_op     = bus.i_m2reg | bus.i_wmem;
        addr       = bus.i_alu[ADDR_W+1:2];
        misaligned = mem_op && (bus.i_alu[1:0] != 2'b00);
        stall      = 1'b0;
        if (!rst) begin
            if (state == ST_IDLE) stall = mem_op && (WAIT_CYCLES != 0);
            else                  stall = (cnt != 4'd0);
        end
        capture = !rst && !stall;
    end

    assign bus.o_stall = stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (stall) begin
                state <= ST_WAIT;
                cnt   <= CNT_LOAD;
            end
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end else begin
            state <= ST_IDLE;
        end
    end

    // Stall cycles (and reset) push a bubble; only the completion cycle captures the instruction.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            bus.o_wreg     <= 1'b0;
            bus.o_m2reg    <= 1'b0;
            bus.o_mo       <= 32'd0;
            bus.o_alu      <= 32'd0;
            bus.o_rn       <= 5'd0;
            bus.o_misalign <= 1'b0;
        end else begin
            bus.o_wreg     <= bus.i_wreg;
            bus.o_m2reg    <= bus.i_m2reg;
            bus.o_mo       <= (bus.i_m2reg && !misaligned) ? mem[addr] : 32'd0;
            bus.o_alu      <= bus.i_alu;
            bus.o_rn       <= bus.i_rn;
            bus.o_misalign <= misaligned;
        end
    end

    // No reset here: memory contents survive rst.
    always_ff @(posedge clk) begin
        if (capture && bus.i_wmem && !misaligned) mem[addr] <= bus.i_b;
    end
endmodule

// File: tb/tb_pipemem_stage.sv
// Randomized bench for pipemem_stage against a transaction-level memory model,
// plus a WAIT_CYCLES=0 instance for the no-stall build.
module tb_pipemem_stage;
    localparam int ADDR_W = 6;
    localparam int WAIT_A = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] ref_mem [2**ADDR_W];

    pipemem_stage_if bus_a ();
    pipemem_stage_if bus_z ();

    pipemem_stage #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pipemem_stage #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Issues one instruction to dut_a at posedge+1, follows it through its stall cycles
    // and checks the MEM/WB result against the reference memory.
    task automatic applyStimulus(input logic wreg, input logic m2reg, input logic wmem,
                                 input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn);
        logic        mem_op;
        logic        mis;
        int          idx;
        int          stalls;
        logic [31:0] exp_mo;
        mem_op = m2reg | wmem;
        mis    = mem_op && (alu % 4 != 0);
        idx    = int'((alu / 4) % (2**ADDR_W));
        exp_mo = (m2reg && !mis) ? ref_mem[idx] : 32'd0;
        bus_a.i_wreg  = wreg;
        bus_a.i_m2reg = m2reg;
        bus_a.i_wmem  = wmem;
        bus_a.i_alu   = alu;
        bus_a.i_b     = b;
        bus_a.i_rn    = rn;
        stalls = 0;
        #1;
        while (bus_a.o_stall === 1'b1 && stalls < 20) begin
            @(posedge clk);
            #1;
            checkOutput("bubble_ctl", {24'd0, bus_a.o_wreg, bus_a.o_m2reg, bus_a.o_misalign, bus_a.o_rn}, 32'd0);
            checkOutput("bubble_data", bus_a.o_alu | bus_a.o_mo, 32'd0);
            stalls++;
            #1;
        end
        checkOutput("stall_cycles", stalls, mem_op ? WAIT_A : 0);
        @(posedge clk);
        #1;
        checkOutput("wreg", bus_a.o_wreg, wreg);
        checkOutput("m2reg", bus_a.o_m2reg, m2reg);
        checkOutput("alu", bus_a.o_alu, alu);
        checkOutput("rn", bus_a.o_rn, rn);
        checkOutput("mo", bus_a.o_mo, exp_mo);
        checkOutput("misalign", bus_a.o_misalign, mis);
        if (wmem && !mis) ref_mem[idx] = b;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] r_alu;
        int          op;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        {bus_a.i_wreg, bus_a.i_m2reg, bus_a.i_wmem} = 3'b000;
        bus_a.i_alu = 32'd0; bus_a.i_b = 32'd0; bus_a.i_rn = 5'd0;
        {bus_z.i_wreg, bus_z.i_m2reg, bus_z.i_wmem} = 3'b000;
        bus_z.i_alu = 32'd0; bus_z.i_b = 32'd0; bus_z.i_rn = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stall", bus_a.o_stall, 1'b0);
        checkOutput("rst_ctl", {24'd0, bus_a.o_wreg, bus_a.o_m2reg, bus_a.o_misalign, bus_a.o_rn}, 32'd0);
        checkOutput("rst_data", bus_a.o_alu | bus_a.o_mo, 32'd0);
        rst = 1'b0;

        // Zero-wait build: store then load back-to-back, never stalling.
        bus_z.i_wmem = 1'b1; bus_z.i_alu = 32'h24; bus_z.i_b = 32'hCAFEF00D;
        #1;
        checkOutput("z_store_stall", bus_z.o_stall, 1'b0);
        @(posedge clk);
        #1;
        bus_z.i_wmem = 1'b0; bus_z.i_m2reg = 1'b1; bus_z.i_wreg = 1'b1; bus_z.i_rn = 5'd3;
        #1;
        checkOutput("z_load_stall", bus_z.o_stall, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("z_load_mo", bus_z.o_mo, 32'hCAFEF00D);
        checkOutput("z_load_m2reg", bus_z.o_m2reg, 1'b1);
        checkOutput("z_load_rn", bus_z.o_rn, 5'd3);
        {bus_z.i_wreg, bus_z.i_m2reg, bus_z.i_wmem} = 3'b000;

        for (int i = 0; i < 2**ADDR_W; i++)
            applyStimulus(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0, 5'd7);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h13, 32'd0, 5'd5);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 5'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 32'h0BADF00D, 5'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h000, 32'd0, 5'd9);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h8, 32'h77777777, 5'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 5'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 5'd0);

        // Store aborted by reset in its second stall cycle.
        bus_a.i_wmem = 1'b1; bus_a.i_alu = 32'h20; bus_a.i_b = 32'h55;
        #1;
        checkOutput("abort_stall1", bus_a.o_stall, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("abort_rst_stall", bus_a.o_stall, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("abort_ctl", {24'd0, bus_a.o_wreg, bus_a.o_m2reg, bus_a.o_misalign, bus_a.o_rn}, 32'd0);
        checkOutput("abort_data", bus_a.o_alu | bus_a.o_mo, 32'd0);
        rst = 1'b0;
        bus_a.i_wmem = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 5'd1);

        for (int n = 0; n < 150; n++) begin
            r_alu = $urandom;
            if ($urandom_range(0, 3) != 0) r_alu[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) r_alu[31:8] = 24'd0;
            op = $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), (op == 1) || (op == 3), (op >= 2),
                          r_alu, $urandom, 5'($urandom_range(0, 31)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipemem_stage.md
PIPEMEM_STAGE -- requirements
Module: pipemem_stage

Interface
REQ-001 Parameter ADDR_W, default 6, is the word-address width; data memory depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, range 0..15, is the number of stall cycles added per memory access.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_wreg  in  1  EX/MEM register-write enable.
REQ-006 i_m2reg  in  1  EX/MEM load: writeback selects memory data.
REQ-007 i_wmem  in  1  EX/MEM store enable.
REQ-008 i_alu  in  32  EX/MEM ALU result; byte address for loads and stores.
REQ-009 i_b  in  32  EX/MEM store data.
REQ-010 i_rn  in  5  EX/MEM destination register number.
REQ-011 o_wreg  out  1  MEM/WB register-write enable.
REQ-012 o_m2reg  out  1  MEM/WB writeback select.
REQ-013 o_mo  out  32  MEM/WB memory read data.
REQ-014 o_alu  out  32  MEM/WB ALU result.
REQ-015 o_rn  out  5  MEM/WB destination register.
REQ-016 o_stall  out  1  combinational; high means upstream stages hold and EX/MEM keeps its inputs stable.
REQ-017 o_misalign  out  1  registered one-cycle pulse flagging a misaligned access.

Function
REQ-018 Memory op = i_m2reg | i_wmem; word address = i_alu[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo the depth.
REQ-019 FSM states: IDLE and WAIT; 4-bit down-counter cnt.
REQ-020 IDLE with no memory op: o_stall=0; the MEM/WB registers capture the i_* values next edge, giving 1-cycle latency; o_mo<=0.
REQ-021 IDLE with memory op and WAIT_CYCLES=0: completes in the same cycle as a pass-through, with no stall.
REQ-022 IDLE with memory op and WAIT_CYCLES>0: o_stall=1; next edge sets state<=WAIT and cnt<=WAIT_CYCLES-1; MEM/WB loads a bubble (o_wreg=0, o_m2reg=0, o_rn=0, o_alu=0, o_mo=0).
REQ-023 WAIT with cnt!=0: o_stall=1, cnt decrements, and a bubble is inserted.
REQ-024 WAIT with cnt==0 is the completion cycle: o_stall=0, the access is performed, MEM/WB captures the inputs, state<=IDLE.
REQ-025 Total occupancy of a memory op is WAIT_CYCLES+1 cycles; exactly one non-bubble MEM/WB update occurs per instruction.
REQ-026 Store: mem[addr]<=i_b at the completion edge only.
REQ-027 Load: o_mo<=mem[addr], read combinationally from the array during the completion cycle.
REQ-028 A load issued immediately after a store to the same address returns the stored value.
REQ-029 Simultaneous i_m2reg and i_wmem: the store is performed and o_mo returns the pre-store contents.
REQ-030 Misaligned access (i_alu[1:0]!=0 during a memory op): no memory write; o_mo<=0; o_misalign=1 for the one cycle after completion; the other MEM/WB fields are captured normally.
REQ-031 In WAIT, input changes are not sampled until the completion cycle; upstream holds its values per o_stall.

Reset
REQ-032 When rst=1 at an edge: state<=IDLE, cnt<=0, and all MEM/WB outputs and o_misalign<=0.
REQ-033 o_stall=0 in any cycle where rst=1.
REQ-034 rst asserted during WAIT aborts the access: the pending store is dropped and no MEM/WB update occurs.
REQ-035 Memory array contents are not affected by rst.

Verification
REQ-036 Store i_alu=0x10, i_b=0xDEADBEEF, WAIT_CYCLES=2 -> o_stall high 2 cycles, low on the 3rd; then a load from 0x10 gives o_mo=0xDEADBEEF, o_m2reg=1.
REQ-037 ALU op i_wreg=1, i_alu=0x1234, i_rn=7 -> next cycle o_wreg=1, o_alu=0x1234, o_rn=7, o_stall never high.
REQ-038 Load at 0x13 -> o_misalign=1 for one cycle, o_mo=0, memory unchanged when re-read at 0x10.
REQ-039 Store to 0x100 with ADDR_W=6 -> a load from 0x000 returns the stored value (wrap-around).
REQ-040 rst pulse in the 2nd stall cycle of a store to 0x20 with i_b=0x55 -> outputs 0, o_stall 0, and a later load from 0x20 does not return 0x55 (previously written 0x0).
REQ-041 WAIT_CYCLES=0 build: back-to-back store then load to the same address -> no stall, and the load returns the stored data.
